// File: rtl/dmem_wait_pkg.sv
// Shared encodings for the wait-state DMEM responder: FSM states, access sizes,
// and the width of the wait counter.
package dmem_wait_pkg;
  localparam int LAT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // mem_byte wins over mem_half_word when both are set
  function automatic size_e size_of(input logic b, input logic h);
    if (b) return SZ_BYTE;
    if (h) return SZ_HALF;
    return SZ_WORD;
  endfunction
endpackage

// File: rtl/dmem_lane_fmt.sv
// Read-data formatter: right-justifies and extends byte/half reads from the
// big-endian raw word, and flags accesses that break natural alignment.
module dmem_lane_fmt
  import dmem_wait_pkg::*;
(
  input  size_e       i_size,
  input  logic        i_sext,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_raw,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);
  // i_raw[31:24] is the byte at the access address itself
  always_comb begin
    o_rdata      = i_raw;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_BYTE: o_rdata = {{24{i_sext & i_raw[31]}}, i_raw[31:24]};
      SZ_HALF: begin
        o_rdata      = {{16{i_sext & i_raw[31]}}, i_raw[31:16]};
        o_misaligned = i_addr_lo[0];
      end
      default: o_misaligned = |i_addr_lo;
    endcase
  end
endmodule

// File: rtl/dmem_wait_resp.sv
// DMEM responder with req/busy/done handshake and LATENCY wait states over a
// big-endian byte array; the request is latched at acceptance.
module dmem_wait_resp
  import dmem_wait_pkg::*;
#(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        write_enable,
  input  logic        mem_byte,
  input  logic        mem_half_word,
  input  logic        sign_extend,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic        misaligned
);
  localparam int AW = $clog2(SIZE);

  logic [7:0]       r_mem [SIZE];
  logic [1:0]       r_state;
  logic [LAT_W-1:0] r_cnt;
  logic [AW-1:0]    r_addr;
  logic [31:0]      r_wdata;
  logic             r_we;
  size_e            r_size;
  logic             r_sext;
  logic             r_busy;
  logic             r_done;
  logic             r_mis;
  logic [31:0]      r_dout;

  logic [3:0][AW-1:0] w_a;
  logic [3:0][7:0]    w_raw;
  logic [31:0]        w_rdata;
  logic               w_mis;
  logic               w_wr;

  // Byte lanes wrap modulo SIZE; only misaligned accesses can actually wrap
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_a[k]       = r_addr + AW'(k);
      w_raw[3 - k] = r_mem[w_a[k]];
    end
  end

  dmem_lane_fmt u_fmt (
    .i_size      (r_size),
    .i_sext      (r_sext),
    .i_addr_lo   (r_addr[1:0]),
    .i_raw       (w_raw),
    .o_rdata     (w_rdata),
    .o_misaligned(w_mis)
  );

  assign w_wr = !reset && (r_state == ST_ACCESS) && r_we && !w_mis;

  always_ff @(posedge clock) begin
    if (w_wr) begin
      case (r_size)
        SZ_BYTE: r_mem[w_a[0]] <= r_wdata[7:0];
        SZ_HALF: begin
          r_mem[w_a[0]] <= r_wdata[15:8];
          r_mem[w_a[1]] <= r_wdata[7:0];
        end
        default: begin
          r_mem[w_a[0]] <= r_wdata[31:24];
          r_mem[w_a[1]] <= r_wdata[23:16];
          r_mem[w_a[2]] <= r_wdata[15:8];
          r_mem[w_a[3]] <= r_wdata[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_size  <= SZ_WORD;
      r_sext  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      case (r_state)
        ST_IDLE: if (req) begin
          r_addr  <= addr[AW-1:0];
          r_wdata <= data_in;
          r_we    <= write_enable;
          r_size  <= size_of(mem_byte, mem_half_word);
          r_sext  <= sign_extend;
          r_cnt   <= LAT_W'(LATENCY);
          r_busy  <= 1'b1;
          r_state <= (LATENCY > 0) ? ST_WAIT : ST_ACCESS;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == LAT_W'(1)) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_done  <= 1'b1;
          r_mis   <= w_mis;
          r_busy  <= 1'b0;
          if (!r_we && !w_mis) r_dout <= w_rdata;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign data_out   = r_dout;
  assign misaligned = r_mis;
endmodule

// File: tb/tb_dmem_wait_resp.sv
// Bench for dmem_wait_resp: two instances (LATENCY 2 and 0), a transaction-level
// model predicting outputs every cycle, plus hand-computed literal checks.
module tb_dmem_wait_resp;
  localparam int SIZE = 16384;
  localparam int LAT [2] = '{2, 0};

  logic clk;
  logic [1:0] rst, req, we, mb, mh, sx;
  logic [1:0][31:0] ad, wd;
  logic b0, b1, dn0, dn1, ms0, ms1;
  logic [31:0] do0, do1;
  logic [1:0] busy, done, mis;
  logic [1:0][31:0] dout;
  assign busy = {b1, b0};
  assign done = {dn1, dn0};
  assign mis  = {ms1, ms0};
  assign dout = {do1, do0};

  dmem_wait_resp #(.SIZE(SIZE), .LATENCY(2)) u_l2 (
    .clock(clk), .reset(rst[0]), .req(req[0]), .addr(ad[0]), .data_in(wd[0]),
    .write_enable(we[0]), .mem_byte(mb[0]), .mem_half_word(mh[0]),
    .sign_extend(sx[0]), .busy(b0), .done(dn0), .data_out(do0), .misaligned(ms0));

  dmem_wait_resp #(.SIZE(SIZE), .LATENCY(0)) u_l0 (
    .clock(clk), .reset(rst[1]), .req(req[1]), .addr(ad[1]), .data_in(wd[1]),
    .write_enable(we[1]), .mem_byte(mb[1]), .mem_half_word(mh[1]),
    .sign_extend(sx[1]), .busy(b1), .done(dn1), .data_out(do1), .misaligned(ms1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  // Model: a request captured at edge tc completes at edge tc+LAT+1
  logic [7:0]  mm [2][SIZE];
  int          cyc = 0;
  int          tcap [2] = '{-1, -1};
  logic [31:0] la [2], lwd [2];
  logic        lwe [2], lb [2], lh [2], ls [2];
  logic        e_busy [2] = '{0, 0};
  logic        e_done [2] = '{0, 0};
  logic        e_mis  [2] = '{0, 0};
  logic [31:0] e_dout [2] = '{0, 0};
  int          mn, mea;
  logic [31:0] mv;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        tcap[d] = -1; e_busy[d] = 0; e_done[d] = 0; e_mis[d] = 0; e_dout[d] = 0;
      end else begin
        e_done[d] = 0;
        e_mis[d]  = 0;
        if (tcap[d] >= 0 && cyc == tcap[d] + LAT[d] + 1) begin
          mn  = lb[d] ? 1 : (lh[d] ? 2 : 4);
          mea = int'(la[d] % SIZE);
          if (mea % mn != 0) e_mis[d] = 1;
          else if (lwe[d]) begin
            for (int i = 0; i < mn; i++)
              mm[d][(mea + i) % SIZE] = 8'(lwd[d] >> (8 * (mn - 1 - i)));
          end else begin
            mv = 0;
            for (int i = 0; i < mn; i++) mv = (mv << 8) | 32'(mm[d][(mea + i) % SIZE]);
            if (mn < 4 && ls[d] && mv[8 * mn - 1]) mv = mv | (32'hFFFF_FFFF << (8 * mn));
            e_dout[d] = mv;
          end
          e_done[d] = 1;
          e_busy[d] = 0;
          tcap[d]   = -1;
        end else if (tcap[d] < 0 && req[d]) begin
          tcap[d] = cyc;
          la[d] = ad[d]; lwd[d] = wd[d]; lwe[d] = we[d];
          lb[d] = mb[d]; lh[d] = mh[d]; ls[d] = sx[d];
          e_busy[d] = 1;
        end
      end
    end
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        total += 4;
        if (busy[d] !== e_busy[d]) begin
          bad++; $display("FAIL busy[%0d] cyc=%0d got=%b want=%b", d, cyc, busy[d], e_busy[d]);
        end
        if (done[d] !== e_done[d]) begin
          bad++; $display("FAIL done[%0d] cyc=%0d got=%b want=%b", d, cyc, done[d], e_done[d]);
        end
        if (mis[d] !== e_mis[d]) begin
          bad++; $display("FAIL misaligned[%0d] cyc=%0d got=%b want=%b", d, cyc, mis[d], e_mis[d]);
        end
        if (dout[d] !== e_dout[d]) begin
          bad++; $display("FAIL data_out[%0d] cyc=%0d got=%h want=%h", d, cyc, dout[d], e_dout[d]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic preload(input int d, input int a, input logic [7:0] b);
    if (d == 0) u_l2.r_mem[a] = b;
    else        u_l0.r_mem[a] = b;
    mm[d][a] = b;
  endtask

  // Issues one request and waits for done; inputs are scrambled after capture
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] w,
                     input logic wr, input logic byt, input logic hw, input logic s,
                     output int lat);
    @(negedge clk);
    ad[d] = a; wd[d] = w; we[d] = wr; mb[d] = byt; mh[d] = hw; sx[d] = s; req[d] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req[d] = 1'b0; ad[d] = '1; wd[d] = '1;
      if (done[d]) begin
        lat = k - 1;
        break;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL txn_timeout dev=%0d addr=%h got=none want=done", d, a);
    end
  endtask

  int lat, cnt;

  initial begin
    rst = 2'b11; req = '0; we = '0; mb = '0; mh = '0; sx = '0; ad = '0; wd = '0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_done", {31'd0, done[0]}, 32'd0);
    chk("rst_dout", dout[0], 32'd0);
    chk("rst_dout_l0", dout[1], 32'd0);
    preload(0, 'h2000, 8'h80); preload(0, 'h2001, 8'h01);
    preload(0, 'h2002, 8'h7F); preload(0, 'h2003, 8'hFF);
    preload(0, 'h2004, 8'h11); preload(0, 'h2005, 8'h22);
    preload(0, 'h2006, 8'h33); preload(0, 'h2007, 8'h44);
    for (int i = 0; i < 4; i++) preload(1, i, 8'h00);
    rst = 2'b00;

    txn(0, 32'h2000, 0, 0, 0, 0, 0, lat);
    chk("word_rd_lat", 32'(lat), 32'd3);
    chk("word_rd", dout[0], 32'h80017FFF);
    txn(0, 32'h2000, 0, 0, 1, 0, 1, lat);
    chk("byte_rd_sx", dout[0], 32'hFFFFFF80);
    txn(0, 32'h2000, 0, 0, 1, 0, 0, lat);
    chk("byte_rd_zx", dout[0], 32'h00000080);
    txn(0, 32'h2002, 0, 0, 0, 1, 1, lat);
    chk("half_rd_sx", dout[0], 32'h00007FFF);

    txn(0, 32'h2001, 32'h000000AB, 1, 1, 0, 0, lat);
    chk("byte_wr_dout_held", dout[0], 32'h00007FFF);
    txn(0, 32'h2000, 0, 0, 0, 0, 0, lat);
    chk("after_byte_wr", dout[0], 32'h80AB7FFF);
    txn(0, 32'h2002, 32'h00001234, 1, 0, 1, 0, lat);
    txn(0, 32'h2000, 0, 0, 0, 0, 0, lat);
    chk("after_half_wr", dout[0], 32'h80AB1234);

    txn(0, 32'h2002, 0, 0, 0, 0, 0, lat);
    chk("mis_rd_flag", {31'd0, mis[0]}, 32'd1);
    chk("mis_rd_dout", dout[0], 32'h80AB1234);
    txn(0, 32'h2001, 32'hCAFEF00D, 1, 0, 0, 0, lat);
    chk("mis_wr_flag", {31'd0, mis[0]}, 32'd1);
    txn(0, 32'h2000, 0, 0, 0, 0, 0, lat);
    chk("mis_wr_no_write", dout[0], 32'h80AB1234);

    // req toggled while busy must not start a second transaction
    @(negedge clk);
    ad[0] = 32'h2000; we[0] = 0; mb[0] = 0; mh[0] = 0; req[0] = 1;
    cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req[0] = (k == 2);
      if (done[0]) cnt++;
    end
    chk("toggle_dones", 32'(cnt), 32'd1);

    // reset during WAIT abandons the write
    @(negedge clk);
    ad[0] = 32'h2004; wd[0] = 32'hDEADBEEF; we[0] = 1; mb[0] = 0; mh[0] = 0; req[0] = 1;
    @(negedge clk);
    req[0] = 0; rst[0] = 1;
    @(negedge clk);
    rst[0] = 0;
    chk("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done[0]) cnt++;
    end
    chk("rst_mid_no_done", 32'(cnt), 32'd0);
    txn(0, 32'h2004, 0, 0, 0, 0, 0, lat);
    chk("rst_mid_no_write", dout[0], 32'h11223344);

    // LATENCY 0: address wrap and back-to-back throughput
    txn(1, 32'h00004000, 32'h5A5AA5A5, 1, 0, 0, 0, lat);
    chk("l0_lat", 32'(lat), 32'd1);
    txn(1, 32'h00000000, 0, 0, 0, 0, 0, lat);
    chk("wrap_alias", dout[1], 32'h5A5AA5A5);
    txn(1, 32'h00004003, 0, 0, 1, 0, 1, lat);
    chk("wrap_byte_sx", dout[1], 32'hFFFFFFA5);

    @(negedge clk);
    ad[1] = 32'h0; we[1] = 0; mb[1] = 0; mh[1] = 0; req[1] = 1;
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done[1]) cnt++;
      if (k == 10) req[1] = 0;
    end
    chk("held_req_dones", 32'(cnt), 32'd5);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_wait_resp.md
Name: dmem_wait_resp

Overview:
Data-memory responder for the multi-cycle processor's DMEM port, with a handshake and configurable wait states. It replaces the zero-wait dmem when the core must stall on memory. Storage is a byte array. Accesses are big-endian: word = {mem[a], mem[a+1], mem[a+2], mem[a+3]}, with bit 0 as the MSB, as elsewhere in the design. It supports byte, half-word and word accesses, sign/zero extension on reads, and flags misaligned accesses.

Parameters:
SIZE, 16384, storage depth in bytes; power of two; address taken modulo SIZE.
LATENCY, 2, wait cycles between request capture and completion; legal range 0..15.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high.
req  in  1  processor request valid; sampled only in IDLE.
addr  in  32  byte address.
data_in  in  32  write data; right-justified for byte/half writes.
write_enable  in  1  1 = write, 0 = read.
mem_byte  in  1  byte access.
mem_half_word  in  1  half-word access; mem_byte takes priority if both are set.
sign_extend  in  1  reads only: 1 = sign-extend, 0 = zero-extend.
busy  out  1  high while a transaction is outstanding.
done  out  1  one-cycle completion pulse.
data_out  out  32  registered read data; held until the next read done.
misaligned  out  1  valid with done; access was not performed.

Behaviour:
- Reset (synchronous):
  - state = IDLE; busy = 0, done = 0, misaligned = 0, data_out = 0; wait counter = 0.
  - Memory contents are not cleared; benches preload mem hierarchically.
- FSM states:
  - IDLE: on req = 1, latch addr, data_in and all control bits; load counter = LATENCY; go to WAIT if LATENCY > 0, else ACCESS.
  - WAIT: decrement the counter each cycle; go to ACCESS when the counter reaches 1.
  - ACCESS: perform the access; pulse done; return to IDLE.
- Latency: a req sampled at edge T produces done high during the cycle after edge T+LATENCY+1. Exactly one done pulse per accepted request.
- busy is high from the edge after capture until the edge that raises done, inclusive of the ACCESS cycle.
- req is ignored while busy. A req still high in the cycle done is high is not captured; it is captured at the next edge in IDLE. Back-to-back throughput is therefore one transaction per LATENCY+2 cycles.
- Latched request: inputs are captured at acceptance, so later changes to addr or data_in have no effect on the transaction.
- Alignment:
  - Byte accesses: any address.
  - Half-word accesses: addr LSB must be 0.
  - Word accesses: low two address bits must be 00.
  - On violation: misaligned = 1 with done, no write, data_out unchanged.
- Writes commit on the edge that enters the done cycle:
  - byte: mem[a] = data_in[24:31].
  - half: mem[a], mem[a+1] = data_in[16:31].
  - word: all four bytes.
- Reads:
  - data_out is updated on the same edge from the current memory contents.
  - Byte/half values are right-justified and extended per the latched sign_extend.
  - Word reads ignore sign_extend.
- Address wrap: the effective address is addr mod SIZE. Aligned accesses never straddle the end of the array.
- Reset mid-transaction: the transaction is abandoned, no write occurs, and no done pulse is issued.
- misaligned is cleared the cycle after done.

Decomposition:
- Package dmem_wait_pkg holds:
  - state encoding (IDLE, WAIT, ACCESS);
  - access-size codes (SZ_BYTE, SZ_HALF, SZ_WORD) derived from mem_byte/mem_half_word;
  - a LATENCY width constant (4 bits).
- One combinational sub-module, dmem_lane_fmt: takes size, sign_extend and raw bytes, and produces the extended read word plus the misalignment check. The FSM, counter and storage stay in the top module.

Test Plan:
- Preload 0x2000..0x2003 = 80 01 7F FF. Word read at 0x2000, LATENCY = 2 -> done exactly 3 cycles after req capture, data_out = 0x80017FFF.
- Byte read at 0x2000 with sign_extend = 1 -> 0xFFFFFF80; same with sign_extend = 0 -> 0x00000080. Half read at 0x2002 with sign_extend = 1 -> 0x00007FFF.
- Byte write 0xAB to 0x2001, then word read at 0x2000 -> 0x80AB7FFF. Half write 0x1234 to 0x2002, then word read -> 0x80AB1234.
- Word read at 0x2002 -> done with misaligned = 1, data_out unchanged. Word write at 0x2001 -> misaligned = 1, memory unchanged.
- req held high for 10 cycles with LATENCY = 0 -> done every 2nd cycle; req toggled while busy -> no extra done pulses.
- Assert reset during WAIT of a word write of 0xDEADBEEF to 0x2004 -> no done, 0x2004 unchanged, busy = 0 the next cycle. Also with LATENCY = 0 and SIZE = 16384, a write to 0x00004000 must alias 0x0.
